// File: rtl/am_insert_pkg.sv
// Shared alignment-marker definitions: Clause 82 per-lane marker table, sync header,
// default spacing. The receive-side deskew/lock logic uses the same table.
package am_insert_pkg;

   localparam int AM_NUM_LANES            = 20;
   localparam int AM_BLOCK_PERIOD_DEFAULT = 16383;

   localparam logic [1:0] AM_SYNC_HDR = 2'b10;

   typedef logic [23:0] am_marker_t;
   typedef logic [65:0] am_block_t;

   // {M0, M1, M2} per PCS lane
   localparam am_marker_t AM_MARKER_TABLE [AM_NUM_LANES] = '{
      24'hC16821, 24'h9D718E, 24'h594BE8, 24'h4D957B, 24'hF50709,
      24'hDD14C2, 24'h9A4A26, 24'h7B4566, 24'hA02476, 24'h68C9FB,
      24'hFD6C99, 24'hB99155, 24'h5CB9B2, 24'h1AF8BD, 24'h83C7CA,
      24'h3536CD, 24'hC4314C, 24'hADD6B7, 24'h5F662A, 24'hC0F0E5
   };

   // BIP3/BIP7 are left at zero; the downstream block fills them in.
   function automatic am_block_t am_build_block(input am_marker_t marker);
      return {AM_SYNC_HDR, marker, 8'h00, ~marker, 8'h00};
   endfunction

endpackage

// File: rtl/am_block_gen.sv
// Combinational lane index to 66-bit alignment-marker block.
module am_block_gen
   import am_insert_pkg::*;
#(
   parameter int NB_LANE_ID = 5
)
(
   input  logic [NB_LANE_ID-1:0] i_lane_index,
   output logic [65:0]           o_am_block
);

   am_marker_t marker;

   always_comb begin
      marker = '0;
      if (int'(i_lane_index) < AM_NUM_LANES) begin
         marker = AM_MARKER_TABLE[i_lane_index];
      end
   end

   assign o_am_block = am_build_block(marker);

endmodule

// File: rtl/am_insert_fsm.sv
// Alignment-marker insertion scheduler: one AM per lane, then a fixed run of data
// slots, repeating. Advances only on cycles where the block slot is enabled and valid.
//
//   state  | meaning
//   INIT   | after reset/resync; holds upstream, next qualified slot starts a group
//   INSERT | emitting AM for lane o_am_lane_index, upstream held
//   DATA   | passing data slots, period counter running
module am_insert_fsm
   import am_insert_pkg::*;
#(
   parameter int N_LANES         = 20,
   parameter int AM_BLOCK_PERIOD = AM_BLOCK_PERIOD_DEFAULT,
   parameter int NB_PERIOD_COUNT = $clog2(AM_BLOCK_PERIOD*N_LANES),
   parameter int NB_LANE_ID      = $clog2(N_LANES)
)
(
   input  logic                  i_clock,
   input  logic                  i_reset,
   input  logic                  i_enable,
   input  logic                  i_valid,
   input  logic                  i_resync,
   output logic                  o_insert_am,
   output logic [NB_LANE_ID-1:0] o_am_lane_index,
   output logic [65:0]           o_am_block,
   output logic                  o_hold_data,
   output logic                  o_am_group_done
);

   localparam logic [2:0] ST_INIT   = 3'b001;
   localparam logic [2:0] ST_INSERT = 3'b010;
   localparam logic [2:0] ST_DATA   = 3'b100;

   localparam logic [NB_LANE_ID-1:0]      LANE_LAST   = NB_LANE_ID'(N_LANES - 1);
   localparam logic [NB_PERIOD_COUNT-1:0] PERIOD_LAST = NB_PERIOD_COUNT'(AM_BLOCK_PERIOD*N_LANES - 1);

   logic [2:0]                 state_q, state_d;
   logic [NB_LANE_ID-1:0]      lane_idx_q, lane_idx_d;
   logic [NB_PERIOD_COUNT-1:0] period_cnt_q, period_cnt_d;
   logic                       group_done_q, group_done_d;
   logic                       slot_qual;
   logic [65:0]                am_block_raw;

   assign slot_qual = i_enable && i_valid;

   always_comb begin
      state_d      = state_q;
      lane_idx_d   = lane_idx_q;
      period_cnt_d = period_cnt_q;
      group_done_d = 1'b0;
      if (i_resync) begin
         state_d      = ST_INIT;
         lane_idx_d   = '0;
         period_cnt_d = '0;
      end else if (slot_qual) begin
         case (state_q)
            ST_INIT: begin
               state_d    = ST_INSERT;
               lane_idx_d = '0;
            end
            ST_INSERT: begin
               if (lane_idx_q >= LANE_LAST) begin
                  state_d      = ST_DATA;
                  lane_idx_d   = '0;
                  period_cnt_d = '0;
                  group_done_d = 1'b1;
               end else begin
                  lane_idx_d = lane_idx_q + 1'b1;
               end
            end
            ST_DATA: begin
               if (period_cnt_q >= PERIOD_LAST) begin
                  state_d      = ST_INSERT;
                  period_cnt_d = '0;
               end else begin
                  period_cnt_d = period_cnt_q + 1'b1;
               end
            end
            default: begin
               state_d      = ST_INIT;
               lane_idx_d   = '0;
               period_cnt_d = '0;
            end
         endcase
      end
   end

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         state_q      <= ST_INIT;
         lane_idx_q   <= '0;
         period_cnt_q <= '0;
         group_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         lane_idx_q   <= lane_idx_d;
         period_cnt_q <= period_cnt_d;
         group_done_q <= group_done_d;
      end
   end

   am_block_gen #(
      .NB_LANE_ID (NB_LANE_ID)
   ) u_am_block_gen (
      .i_lane_index (lane_idx_q),
      .o_am_block   (am_block_raw)
   );

   assign o_insert_am     = (state_q == ST_INSERT) && slot_qual;
   assign o_hold_data     = (state_q != ST_DATA);
   assign o_am_block      = (state_q == ST_INSERT) ? am_block_raw : '0;
   assign o_am_lane_index = lane_idx_q;
   assign o_am_group_done = group_done_q;

endmodule

// File: tb/tb_am_insert_fsm.sv
// Directed self-checking bench for am_insert_fsm with 20 lanes and 4 blocks per lane
// between groups (80 data slots per period).
module tb_am_insert_fsm;

   localparam int N_LANES         = 20;
   localparam int AM_BLOCK_PERIOD = 4;

   logic        i_clock = 1'b0;
   logic        i_reset;
   logic        i_enable;
   logic        i_valid;
   logic        i_resync;
   logic        o_insert_am;
   logic [4:0]  o_am_lane_index;
   logic [65:0] o_am_block;
   logic        o_hold_data;
   logic        o_am_group_done;

   int checks   = 0;
   int failures = 0;

   am_insert_fsm #(
      .N_LANES         (N_LANES),
      .AM_BLOCK_PERIOD (AM_BLOCK_PERIOD)
   ) dut (
      .i_clock         (i_clock),
      .i_reset         (i_reset),
      .i_enable        (i_enable),
      .i_valid         (i_valid),
      .i_resync        (i_resync),
      .o_insert_am     (o_insert_am),
      .o_am_lane_index (o_am_lane_index),
      .o_am_block      (o_am_block),
      .o_hold_data     (o_hold_data),
      .o_am_group_done (o_am_group_done)
   );

   always #5 i_clock = ~i_clock;

   function automatic logic [23:0] ref_marker(input int lane);
      case (lane)
         0:  return 24'hC16821;  1:  return 24'h9D718E;  2:  return 24'h594BE8;
         3:  return 24'h4D957B;  4:  return 24'hF50709;  5:  return 24'hDD14C2;
         6:  return 24'h9A4A26;  7:  return 24'h7B4566;  8:  return 24'hA02476;
         9:  return 24'h68C9FB;  10: return 24'hFD6C99;  11: return 24'hB99155;
         12: return 24'h5CB9B2;  13: return 24'h1AF8BD;  14: return 24'h83C7CA;
         15: return 24'h3536CD;  16: return 24'hC4314C;  17: return 24'hADD6B7;
         18: return 24'h5F662A;  19: return 24'hC0F0E5;
         default: return 24'h000000;
      endcase
   endfunction

   function automatic logic [65:0] ref_block(input int lane);
      logic [23:0] m;
      m = ref_marker(lane);
      return {2'b10, m, 8'h00, ~m, 8'h00};
   endfunction

   // Inputs change 1 time unit after the rising edge; outputs are sampled 4 units after.
   task automatic next_cycle();
      @(posedge i_clock);
      #1;
   endtask

   task automatic apply_reset();
      i_reset  = 1'b1;
      i_enable = 1'b1;
      i_valid  = 1'b1;
      i_resync = 1'b0;
      @(posedge i_clock);
      #1;
      @(posedge i_clock);
      #1;
      i_reset = 1'b0;
   endtask

   task automatic test_reset();
      i_reset  = 1'b1;
      i_enable = 1'b1;
      i_valid  = 1'b1;
      i_resync = 1'b0;
      #3;
      checks++;
      if (o_insert_am !== 1'b0) begin
         failures++; $display("FAIL reset_insert: got %b want 0", o_insert_am);
      end
      checks++;
      if (o_hold_data !== 1'b1) begin
         failures++; $display("FAIL reset_hold: got %b want 1", o_hold_data);
      end
      checks++;
      if (o_am_lane_index !== 5'd0) begin
         failures++; $display("FAIL reset_lane: got %0d want 0", o_am_lane_index);
      end
      checks++;
      if (o_am_block !== 66'd0) begin
         failures++; $display("FAIL reset_block: got %h want 0", o_am_block);
      end
      checks++;
      if (o_am_group_done !== 1'b0) begin
         failures++; $display("FAIL reset_done: got %b want 0", o_am_group_done);
      end
   endtask

   task automatic test_sequence();
      int          exp_lane;
      logic        exp_ins, exp_hold, exp_done;
      logic [65:0] exp_blk;
      apply_reset();
      for (int c = 0; c <= 121; c++) begin
         if (c >= 1 && c <= 20) begin
            exp_ins = 1'b1; exp_lane = c - 1;
         end else if (c >= 101 && c <= 120) begin
            exp_ins = 1'b1; exp_lane = c - 101;
         end else begin
            exp_ins = 1'b0; exp_lane = 0;
         end
         exp_hold = exp_ins || (c == 0);
         exp_done = (c == 21) || (c == 121);
         exp_blk  = exp_ins ? ref_block(exp_lane) : 66'd0;
         #3;
         checks++;
         if (o_insert_am !== exp_ins || o_hold_data !== exp_hold ||
             o_am_lane_index !== 5'(exp_lane) || o_am_group_done !== exp_done ||
             o_am_block !== exp_blk) begin
            failures++;
            $display("FAIL seq cycle %0d: got ins=%b hold=%b lane=%0d done=%b blk=%h want ins=%b hold=%b lane=%0d done=%b blk=%h",
                     c, o_insert_am, o_hold_data, o_am_lane_index, o_am_group_done, o_am_block,
                     exp_ins, exp_hold, exp_lane, exp_done, exp_blk);
         end
         next_cycle();
      end
   endtask

   task automatic test_lane0_content();
      apply_reset();
      next_cycle();
      #3;
      checks++;
      if (o_am_block[65:64] !== 2'b10) begin
         failures++; $display("FAIL lane0_sync: got %b want 10", o_am_block[65:64]);
      end
      checks++;
      if (o_am_block[39:32] !== 8'h00 || o_am_block[7:0] !== 8'h00) begin
         failures++; $display("FAIL lane0_bip: got %h/%h want 00/00", o_am_block[39:32], o_am_block[7:0]);
      end
      checks++;
      if (o_am_block[31:8] !== ~o_am_block[63:40]) begin
         failures++; $display("FAIL lane0_inverse: got %h want %h", o_am_block[31:8], ~o_am_block[63:40]);
      end
      checks++;
      if (o_am_block[63:40] !== 24'hC16821) begin
         failures++; $display("FAIL lane0_marker: got %h want C16821", o_am_block[63:40]);
      end
      checks++;
      if (o_am_block[63:40] !== am_insert_pkg::AM_MARKER_TABLE[0]) begin
         failures++; $display("FAIL lane0_pkg_entry: got %h want %h", o_am_block[63:40], am_insert_pkg::AM_MARKER_TABLE[0]);
      end
   endtask

   task automatic test_stall();
      apply_reset();
      repeat (8) next_cycle();
      for (int s = 0; s < 3; s++) begin
         i_valid = 1'b0;
         #3;
         checks++;
         if (o_am_lane_index !== 5'd7 || o_hold_data !== 1'b1 || o_insert_am !== 1'b0) begin
            failures++;
            $display("FAIL stall_hold %0d: got lane=%0d hold=%b ins=%b want lane=7 hold=1 ins=0",
                     s, o_am_lane_index, o_hold_data, o_insert_am);
         end
         next_cycle();
      end
      i_valid = 1'b1;
      #3;
      checks++;
      if (o_am_lane_index !== 5'd7 || o_insert_am !== 1'b1 || o_am_block !== ref_block(7)) begin
         failures++;
         $display("FAIL stall_resume_lane7: got lane=%0d ins=%b blk=%h want lane=7 ins=1 blk=%h",
                  o_am_lane_index, o_insert_am, o_am_block, ref_block(7));
      end
      next_cycle();
      #3;
      checks++;
      if (o_am_lane_index !== 5'd8 || o_insert_am !== 1'b1) begin
         failures++;
         $display("FAIL stall_next_lane8: got lane=%0d ins=%b want lane=8 ins=1", o_am_lane_index, o_insert_am);
      end
   endtask

   task automatic test_resync();
      apply_reset();
      repeat (58) next_cycle();
      i_resync = 1'b1;
      #3;
      checks++;
      if (o_hold_data !== 1'b0) begin
         failures++; $display("FAIL resync_in_data: got hold=%b want 0", o_hold_data);
      end
      next_cycle();
      i_resync = 1'b0;
      #3;
      checks++;
      if (o_insert_am !== 1'b0 || o_hold_data !== 1'b1 || o_am_lane_index !== 5'd0) begin
         failures++;
         $display("FAIL resync_init: got ins=%b hold=%b lane=%0d want ins=0 hold=1 lane=0",
                  o_insert_am, o_hold_data, o_am_lane_index);
      end
      next_cycle();
      for (int k = 0; k < N_LANES; k++) begin
         #3;
         checks++;
         if (o_insert_am !== 1'b1 || o_hold_data !== 1'b1 || o_am_lane_index !== 5'(k)) begin
            failures++;
            $display("FAIL resync_group lane %0d: got ins=%b hold=%b lane=%0d",
                     k, o_insert_am, o_hold_data, o_am_lane_index);
         end
         next_cycle();
      end
      #3;
      checks++;
      if (o_hold_data !== 1'b0 || o_am_group_done !== 1'b1) begin
         failures++;
         $display("FAIL resync_after_group: got hold=%b done=%b want hold=0 done=1", o_hold_data, o_am_group_done);
      end
   endtask

   task automatic test_resync_priority();
      // Resync on the slot that would finish the group: no done pulse, back to INIT.
      apply_reset();
      repeat (20) next_cycle();
      i_resync = 1'b1;
      next_cycle();
      i_resync = 1'b0;
      #3;
      checks++;
      if (o_am_group_done !== 1'b0 || o_hold_data !== 1'b1 || o_insert_am !== 1'b0) begin
         failures++;
         $display("FAIL resync_last_lane: got done=%b hold=%b ins=%b want done=0 hold=1 ins=0",
                  o_am_group_done, o_hold_data, o_insert_am);
      end
      // Resync must win over a low enable.
      repeat (5) next_cycle();
      i_enable = 1'b0;
      i_resync = 1'b1;
      next_cycle();
      i_resync = 1'b0;
      #3;
      checks++;
      if (o_am_lane_index !== 5'd0 || o_hold_data !== 1'b1 || o_insert_am !== 1'b0 || o_am_block !== 66'd0) begin
         failures++;
         $display("FAIL resync_enable_low: got lane=%0d hold=%b ins=%b blk=%h want lane=0 hold=1 ins=0 blk=0",
                  o_am_lane_index, o_hold_data, o_insert_am, o_am_block);
      end
      next_cycle();
      i_enable = 1'b1;
      next_cycle();
      #3;
      checks++;
      if (o_am_lane_index !== 5'd0 || o_insert_am !== 1'b1) begin
         failures++;
         $display("FAIL resync_restart_lane0: got lane=%0d ins=%b want lane=0 ins=1", o_am_lane_index, o_insert_am);
      end
   endtask

   task automatic test_enable();
      int n_data;
      bit seen;
      apply_reset();
      repeat (71) next_cycle();
      for (int s = 0; s < 10; s++) begin
         i_enable = 1'b0;
         #3;
         checks++;
         if (o_hold_data !== 1'b0 || o_insert_am !== 1'b0) begin
            failures++;
            $display("FAIL enable_low %0d: got hold=%b ins=%b want hold=0 ins=0", s, o_hold_data, o_insert_am);
         end
         next_cycle();
      end
      i_enable = 1'b1;
      n_data = 0;
      seen   = 1'b0;
      for (int c = 0; c < 100 && !seen; c++) begin
         #3;
         if (o_insert_am === 1'b1) begin
            seen = 1'b1;
         end else begin
            if (o_hold_data === 1'b0) n_data++;
            next_cycle();
         end
      end
      checks++;
      if (!seen || n_data != 30) begin
         failures++;
         $display("FAIL enable_resume_count: got %0d data slots (group seen=%0d) want 30", n_data, seen);
      end
      checks++;
      if (o_am_lane_index !== 5'd0 || o_am_block !== ref_block(0)) begin
         failures++;
         $display("FAIL enable_group_lane0: got lane=%0d blk=%h want lane=0 blk=%h",
                  o_am_lane_index, o_am_block, ref_block(0));
      end
   endtask

   task automatic test_async_reset();
      apply_reset();
      repeat (13) next_cycle();
      #3;
      checks++;
      if (o_am_lane_index !== 5'd12 || o_insert_am !== 1'b1) begin
         failures++;
         $display("FAIL areset_pre_lane12: got lane=%0d ins=%b want lane=12 ins=1", o_am_lane_index, o_insert_am);
      end
      i_reset = 1'b1;
      #1;
      checks++;
      if (o_insert_am !== 1'b0 || o_hold_data !== 1'b1 || o_am_lane_index !== 5'd0 ||
          o_am_block !== 66'd0 || o_am_group_done !== 1'b0) begin
         failures++;
         $display("FAIL areset_immediate: got ins=%b hold=%b lane=%0d blk=%h done=%b want 0 1 0 0 0",
                  o_insert_am, o_hold_data, o_am_lane_index, o_am_block, o_am_group_done);
      end
      next_cycle();
      i_reset = 1'b0;
      #3;
      checks++;
      if (o_insert_am !== 1'b0 || o_hold_data !== 1'b1) begin
         failures++;
         $display("FAIL areset_init: got ins=%b hold=%b want ins=0 hold=1", o_insert_am, o_hold_data);
      end
      next_cycle();
      #3;
      checks++;
      if (o_am_lane_index !== 5'd0 || o_insert_am !== 1'b1) begin
         failures++;
         $display("FAIL areset_lane0: got lane=%0d ins=%b want lane=0 ins=1", o_am_lane_index, o_insert_am);
      end
      next_cycle();
      #3;
      checks++;
      if (o_am_lane_index !== 5'd1) begin
         failures++;
         $display("FAIL areset_lane1: got lane=%0d want 1", o_am_lane_index);
      end
   endtask

   initial begin
      test_reset();
      test_sequence();
      test_lane0_content();
      test_stall();
      test_resync();
      test_resync_priority();
      test_enable();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/am_insert_fsm.md
AM_INSERT_FSM -- requirements
Module: am_insert_fsm

Interface
REQ-001 Parameter N_LANES, default 20: number of PCS lanes, equal to the number of AM blocks per insertion group.
REQ-002 Parameter AM_BLOCK_PERIOD, default 16383: data blocks per lane between AM groups.
REQ-003 Parameter NB_PERIOD_COUNT, default $clog2(AM_BLOCK_PERIOD*N_LANES): width of the aggregate data counter.
REQ-004 Parameter NB_LANE_ID, default $clog2(N_LANES): width of the lane index.
REQ-005 i_clock  input  1  sole clock; all state updates on the rising edge.
REQ-006 i_reset  input  1  asynchronous, active-high reset.
REQ-007 i_enable  input  1  block enable; low freezes all state.
REQ-008 i_valid  input  1  block-rate qualifier; one 66b block slot per valid cycle.
REQ-009 i_resync  input  1  synchronous restart of the AM schedule.
REQ-010 o_insert_am  output  1  current slot carries an AM block.
REQ-011 o_am_lane_index  output  NB_LANE_ID  lane number of the AM in the current slot.
REQ-012 o_am_block  output  66  AM block for the current slot.
REQ-013 o_hold_data  output  1  upstream must not advance its data this slot.
REQ-014 o_am_group_done  output  1  one-cycle pulse after the last AM of a group.

Function
REQ-015 The FSM SHALL be one-hot with three states: INIT, INSERT, DATA.
REQ-016 State, counters and registered outputs SHALL update only on cycles where i_enable && i_valid is high; otherwise they hold.
REQ-017 INIT: o_hold_data=1 and o_insert_am=0; the next qualified cycle SHALL go to INSERT with lane index 0.
  - Rationale: an AM group goes out first so the receiver can lock quickly.
REQ-018 INSERT: o_insert_am=i_valid&&i_enable and o_hold_data=1.
  - Each qualified cycle increments the lane index.
  - After lane N_LANES-1 the FSM SHALL go to DATA, clear the period counter to 0 and reset the lane index to 0.
REQ-019 DATA: o_insert_am=0 and o_hold_data=0.
  - Each qualified cycle increments the period counter.
  - On the qualified cycle where the counter equals AM_BLOCK_PERIOD*N_LANES-1, the FSM SHALL go to INSERT.
REQ-020 Resulting order: exactly N_LANES AM slots, then exactly AM_BLOCK_PERIOD*N_LANES data slots, repeating without drift.
REQ-021 o_insert_am, o_hold_data and o_am_block SHALL be combinational from state and lane index: zero latency, valid in the same cycle as the slot.
REQ-022 o_am_block SHALL be built as follows:
  - Sync header 2'b10.
  - Payload {M0,M1,M2,BIP3,M4,M5,M6,BIP7}, where M4..M6 are the bitwise inverse of M0..M2.
  - M0..M2 taken from the package table indexed by o_am_lane_index.
  - BIP3 and BIP7 are 8'h00; BIP is filled by the downstream block.
REQ-023 When not in INSERT, o_am_block SHALL be all-zero.
REQ-024 o_am_group_done SHALL be registered, high for exactly one cycle after the qualified cycle that sends lane N_LANES-1.
REQ-025 i_resync high on a clock edge SHALL force INIT, clear both counters and clear o_am_group_done.
  - This takes priority over i_enable, i_valid and any in-progress group.
  - A partially sent group is abandoned; the next group restarts at lane 0.
REQ-026 A stall (i_valid low) mid-group SHALL hold o_am_lane_index; the group resumes at the same lane with no slot skipped or repeated.
REQ-027 The period counter SHALL never exceed AM_BLOCK_PERIOD*N_LANES-1.
REQ-028 The lane index SHALL never exceed N_LANES-1.

Reset
REQ-029 On i_reset, asynchronously: state=INIT, period counter=0, lane index=0, o_am_group_done=0.
  - Outputs then read o_insert_am=0, o_hold_data=1, o_am_lane_index=0, o_am_block=0.
REQ-030 Reset asserted mid-group SHALL abandon the group immediately, and the next group SHALL restart at lane 0 after release.

Structure
REQ-031 A shared package SHALL hold:
  - the N_LANES x 24-bit AM marker table (M0..M2 per lane, IEEE 802.3 Clause 82 values);
  - the AM sync header constant;
  - the default AM_BLOCK_PERIOD.
  - The receive-side deskew and lock logic uses the same table.
REQ-032 One sub-module, am_block_gen, SHALL map lane index to the 66-bit AM block.
  - It is purely combinational.
  - It SHALL be instantiated once.

Verification
REQ-033 Use AM_BLOCK_PERIOD=4, N_LANES=20, continuous valid.
  - Stimulus: release reset.
  - Required: 20 o_insert_am cycles with lanes 0..19, then 80 o_hold_data=0 cycles, then 20 AM cycles again.
  - o_am_group_done pulses in cycles 21 and 121.
REQ-034 Lane-0 content check.
  - Stimulus: INSERT at lane 0.
  - Required: o_am_block[65:64]=2'b10, payload bytes 3 and 7 = 8'h00, bytes 4..6 = ~bytes 0..2, and bytes 0..2 match the package entry 0.
REQ-035 Stall mid-group.
  - Stimulus: i_valid low for 3 cycles while at lane 7.
  - Required: o_am_lane_index stays 7 and o_hold_data stays 1; when valid returns, lane 7 is emitted once and then lane 8.
REQ-036 Resync during DATA.
  - Stimulus: i_resync pulse at data count 37.
  - Required: INIT, then the next qualified cycle emits lane 0, with 20 AMs before any data.
REQ-037 Enable low.
  - Stimulus: i_enable low for 10 cycles during DATA at count 50.
  - Required: the count holds at 50, and the group starts exactly 30 qualified cycles after i_enable returns high.
REQ-038 Asynchronous reset mid-group.
  - Stimulus: i_reset asserted between edges at lane 12.
  - Required: outputs go to reset values before the next edge, and lane 0 follows release.
